// File: rtl/lsu_sequencer.sv
// Load/store sequencer: splits byte/half/word accesses into single-cycle word or byte beats on a big-endian memory.
// Optional macro LSU_MISALIGNED_WORD_EN: misaligned in-range words run as four byte beats instead of erroring.
module lsu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 32'h10000,
  parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 32'h1FFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  localparam int DW = DATA_WIDTH;
  localparam int BW = BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      beat_q, beat_d, last_q, last_d, beat_next;
  logic            we_q, we_d, sgn_q, sgn_d, byte_mode_q, byte_mode_d;
  logic            err_q, err_d;
  logic [DW-1:0]   addr_q, addr_d, wdata_q, wdata_d, acc_q, acc_d, rdata_q, rdata_d;
  logic            mem_we_q, mem_we_d, mem_byte_op_q, mem_byte_op_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d, captured;

  logic [1:0]      n_m1, last_in;
  logic [DW:0]     last_addr;
  logic            misaligned, in_range, legal, byte_mode_in;

  // Byte idx of a multi-byte beat plan, most significant byte first.
  function automatic logic [BW-1:0] pick_byte(input logic [DW-1:0] data,
                                              input logic [1:0] last,
                                              input logic [1:0] idx);
    logic [1:0] k;
    k = last - idx;
    return data[int'(k)*BW +: BW];
  endfunction

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input logic byte_mode,
                                           input logic [1:0] last, input logic sgn);
    if (!byte_mode || last == 2'd3) return v;
    if (last == 2'd0) return {{(DW-BW){sgn & v[BW-1]}}, v[BW-1:0]};
    return {{(DW-2*BW){sgn & v[2*BW-1]}}, v[2*BW-1:0]};
  endfunction

  always_comb begin
    case (req_size_i)
      2'b00:   n_m1 = 2'd0;
      2'b01:   n_m1 = 2'd1;
      default: n_m1 = 2'd3;
    endcase
    misaligned   = req_size_i[1] && (req_addr_i[1:0] != 2'b00);
    // Extra carry bit makes an address wrap past the top count as out of range.
    last_addr    = {1'b0, req_addr_i} + {{(DW-1){1'b0}}, n_m1};
    in_range     = (req_addr_i >= START_ADDRESS) && (last_addr <= {1'b0, END_ADDRESS});
`ifdef LSU_MISALIGNED_WORD_EN
    legal        = in_range;
`else
    legal        = in_range && !misaligned;
`endif
    byte_mode_in = !(req_size_i[1] && !misaligned);
    last_in      = byte_mode_in ? n_m1 : 2'd0;
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    last_d        = last_q;
    we_d          = we_q;
    sgn_d         = sgn_q;
    byte_mode_d   = byte_mode_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    acc_d         = acc_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    mem_we_d      = mem_we_q;
    mem_byte_op_d = mem_byte_op_q;
    mem_addr_d    = mem_addr_q;
    mem_wd_d      = mem_wd_q;
    beat_next     = beat_q + 2'd1;
    captured      = byte_mode_q ? {acc_q[DW-BW-1:0], mem_rd_i[BW-1:0]} : mem_rd_i;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          sgn_d       = req_signed_i;
          byte_mode_d = byte_mode_in;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          last_d      = last_in;
          beat_d      = 2'd0;
          acc_d       = '0;
          rdata_d     = '0;
          if (legal) begin
            state_d       = BEAT;
            err_d         = 1'b0;
            mem_we_d      = req_we_i;
            mem_byte_op_d = byte_mode_in;
            mem_addr_d    = req_addr_i;
            mem_wd_d      = byte_mode_in ? {pick_byte(req_wdata_i, last_in, 2'd0), {(DW-BW){1'b0}}}
                                         : req_wdata_i;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      BEAT: begin
        acc_d = captured;
        if (beat_q == last_q) begin
          state_d       = RESP;
          rdata_d       = we_q ? '0 : extend(captured, byte_mode_q, last_q, sgn_q);
          mem_we_d      = 1'b0;
          mem_byte_op_d = 1'b0;
          mem_addr_d    = '0;
          mem_wd_d      = '0;
        end else begin
          beat_d     = beat_next;
          mem_addr_d = addr_q + {{(DW-2){1'b0}}, beat_next};
          mem_wd_d   = {pick_byte(wdata_q, last_q, beat_next), {(DW-BW){1'b0}}};
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      last_q        <= '0;
      we_q          <= 1'b0;
      sgn_q         <= 1'b0;
      byte_mode_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      acc_q         <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_byte_op_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wd_q      <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
      we_q          <= we_d;
      sgn_q         <= sgn_d;
      byte_mode_q   <= byte_mode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      acc_q         <= acc_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      mem_we_q      <= mem_we_d;
      mem_byte_op_q <= mem_byte_op_d;
      mem_addr_q    <= mem_addr_d;
      mem_wd_q      <= mem_wd_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_err_o     = err_q;
  assign rsp_rdata_o   = rdata_q;
  assign mem_we_o      = mem_we_q;
  assign mem_byte_op_o = mem_byte_op_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wd_o      = mem_wd_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: big-endian byte memory model plus a byte-array reference of the access semantics.
module tb_lsu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_we_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  logic [7:0] ram  [0:65535];
  logic [7:0] gold [0:65535];
  int checks = 0;
  int errors = 0;

  lsu_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_we_o(mem_we_o), .mem_byte_op_o(mem_byte_op_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory covering 0x10000..0x1FFFF: combinational read, negedge write.
  always_comb begin
    mem_rd_i = '0;
    if (mem_addr_o >= 32'h10000 && mem_addr_o <= 32'h1FFFF) begin
      if (mem_byte_op_o) mem_rd_i = {24'h0, ram[mem_addr_o[15:0]]};
      else if (mem_addr_o <= 32'h1FFFC)
        mem_rd_i = {ram[mem_addr_o[15:0]], ram[mem_addr_o[15:0] + 16'd1],
                    ram[mem_addr_o[15:0] + 16'd2], ram[mem_addr_o[15:0] + 16'd3]};
    end
  end

  always @(negedge clk_i) begin
    if (mem_we_o && mem_addr_o >= 32'h10000 && mem_addr_o <= 32'h1FFFF) begin
      if (mem_byte_op_o) ram[mem_addr_o[15:0]] = mem_wd_o[31:24];
      else if (mem_addr_o <= 32'h1FFFC) begin
        ram[mem_addr_o[15:0]]         = mem_wd_o[31:24];
        ram[mem_addr_o[15:0] + 16'd1] = mem_wd_o[23:16];
        ram[mem_addr_o[15:0] + 16'd2] = mem_wd_o[15:8];
        ram[mem_addr_o[15:0] + 16'd3] = mem_wd_o[7:0];
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: what the access should return given the byte image in gold; stores update gold.
  function automatic void model(input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output bit err, output int lat);
    int n;
    longint unsigned a, last, v;
    bit mis;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a    = {32'h0, addr};
    last = a + longint'(n) - 1;
    mis  = (n == 4) && (a % 4 != 0);
    err  = (a < 64'h10000) || (last > 64'h1FFFF);
`ifndef LSU_MISALIGNED_WORD_EN
    err  = err || mis;
`endif
    rdata = '0;
    if (err) begin
      lat = 1;
      return;
    end
    lat = (n == 1) ? 2 : (n == 2) ? 3 : (mis ? 5 : 2);
    if (we) begin
      for (int i = 0; i < n; i++)
        gold[int'(a - 64'h10000) + i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(gold[int'(a - 64'h10000) + i]);
      if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      rdata = v[31:0];
    end
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [7:0] b);
    ram[addr[15:0]]  = b;
    gold[addr[15:0]] = b;
  endtask

  // Issue one request and watch up to 10 cycles for its response; lat=0 means none arrived.
  task automatic do_access(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output bit err, output int lat,
                           output bit we_seen, output bit byte_op_seen);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = 0; rdata = '0; err = 1'b0; we_seen = 1'b0; byte_op_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (mem_we_o) we_seen = 1'b1;
      if (mem_byte_op_o) byte_op_seen = 1'b1;
      if (rsp_valid_o) begin
        lat = k; rdata = rsp_rdata_o; err = rsp_err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rsp got valid=%b err=%b rdata=%h want 0/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    checks++; if (mem_we_o !== 1'b0 || mem_byte_op_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wd_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_mem got we=%b bop=%b addr=%h wd=%h want zeros", mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release got ready=%b valid=%b want 1/0", req_ready_o, rsp_valid_o); end
  endtask

  task automatic test_word_load();
    logic [31:0] rd; bit err, ws, bs; int lat;
    preload(32'h10000, 8'h12); preload(32'h10001, 8'h34);
    preload(32'h10002, 8'h56); preload(32'h10003, 8'h78);
    do_access(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, rd, err, lat, ws, bs);
    checks++; if (rd !== 32'h12345678 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL word_load got rdata=%h err=%b want 12345678/0", rd, err); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL word_load_latency got=%0d want=2", lat); end
    checks++; if (bs !== 1'b0 || ws !== 1'b0) begin
      errors++; $display("[TB] FAIL word_load_beat got byte_op=%b we=%b want 0/0", bs, ws); end
  endtask

  task automatic test_byte_load();
    logic [31:0] rd; bit err, ws, bs; int lat;
    preload(32'h10003, 8'h80);
    do_access(1'b0, 2'b00, 1'b1, 32'h10003, 32'h0, rd, err, lat, ws, bs);
    checks++; if (rd !== 32'hFFFFFF80 || err !== 1'b0 || lat !== 2 || ws !== 1'b0) begin
      errors++; $display("[TB] FAIL lb_signed got rdata=%h err=%b lat=%0d we=%b want ffffff80/0/2/0", rd, err, lat, ws); end
    do_access(1'b0, 2'b00, 1'b0, 32'h10003, 32'h0, rd, err, lat, ws, bs);
    checks++; if (rd !== 32'h00000080 || err !== 1'b0 || lat !== 2 || ws !== 1'b0) begin
      errors++; $display("[TB] FAIL lbu got rdata=%h err=%b lat=%0d we=%b want 00000080/0/2/0", rd, err, lat, ws); end
  endtask

  task automatic test_half_store();
    logic [31:0] rd, mrd; bit err, ws, bs, merr; int lat, mlat;
    model(1'b1, 2'b01, 1'b0, 32'h10002, 32'h0000BEEF, mrd, merr, mlat);
    do_access(1'b1, 2'b01, 1'b0, 32'h10002, 32'h0000BEEF, rd, err, lat, ws, bs);
    checks++; if (ram[16'h0002] !== 8'hBE || ram[16'h0003] !== 8'hEF) begin
      errors++; $display("[TB] FAIL half_store_mem got %h %h want be ef", ram[16'h0002], ram[16'h0003]); end
    checks++; if (lat !== 3 || err !== 1'b0 || rd !== 32'h0 || ws !== 1'b1) begin
      errors++; $display("[TB] FAIL half_store_rsp got lat=%0d err=%b rdata=%h we=%b want 3/0/0/1", lat, err, rd, ws); end
    do_access(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, rd, err, lat, ws, bs);
    checks++; if (rd !== 32'h1234BEEF || err !== 1'b0) begin
      errors++; $display("[TB] FAIL half_store_readback got %h err=%b want 1234beef/0", rd, err); end
  endtask

  task automatic test_misaligned_word();
    logic [31:0] rd; bit err, ws, bs; int lat;
    preload(32'h10000, 8'h12); preload(32'h10001, 8'h34); preload(32'h10002, 8'h56);
    preload(32'h10003, 8'h78); preload(32'h10004, 8'h9A);
    do_access(1'b0, 2'b10, 1'b0, 32'h10001, 32'h0, rd, err, lat, ws, bs);
`ifdef LSU_MISALIGNED_WORD_EN
    checks++; if (rd !== 32'h3456789A || err !== 1'b0 || lat !== 5) begin
      errors++; $display("[TB] FAIL misaligned_word got rdata=%h err=%b lat=%0d want 3456789a/0/5", rd, err, lat); end
`else
    checks++; if (rd !== 32'h0 || err !== 1'b1 || lat !== 1) begin
      errors++; $display("[TB] FAIL misaligned_word got rdata=%h err=%b lat=%0d want 0/1/1", rd, err, lat); end
`endif
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; bit err, ws, bs; int lat;
    logic [31:0] addrs [3] = '{32'h00020000, 32'h0001FFFF, 32'h0000FFFF};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b00};
    bit          wes   [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_access(wes[i], sizes[i], 1'b0, addrs[i], 32'hA5A5A5A5, rd, err, lat, ws, bs);
      checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || ws !== 1'b0) begin
        errors++; $display("[TB] FAIL out_of_range[%0d] got err=%b rdata=%h lat=%0d we=%b want 1/0/1/0", i, err, rd, lat, ws); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    preload(32'h10010, 8'h11); preload(32'h10011, 8'h22);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b01;
    req_signed_i = 1'b0; req_addr_i = 32'h10010; req_wdata_i = 32'h0000BEEF;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    checks++; if (mem_we_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_beat0 got we=%b want 1", mem_we_o); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_we got=%b want 0", mem_we_o); end
    repeat (2) begin @(negedge clk_i); if (rsp_valid_o) seen = 1'b1; end
    rst_ni = 1'b1;
    repeat (3) begin @(negedge clk_i); if (rsp_valid_o) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_rsp got rsp_valid seen=%b want 0", seen); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_ready got=%b want 1", req_ready_o); end
    checks++; if (ram[16'h0011] !== gold[16'h0011] || ram[16'h0010] !== gold[16'h0010]) begin
      errors++; $display("[TB] FAIL reset_mid_mem got %h %h want %h %h", ram[16'h0010], ram[16'h0011], gold[16'h0010], gold[16'h0011]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd; bit err, ws, bs, merr, we, sgn; int lat, mlat, sel;
    logic [1:0] size;
    logic [31:0] wild [4] = '{32'hFFFFFFFE, 32'h0000FFFE, 32'h00020000, 32'h0000FFFF};
    for (int t = 0; t < 60; t++) begin
      sel  = $urandom_range(0, 9);
      if (sel <= 6) addr = 32'h10000 + $urandom_range(0, 63);
      else if (sel <= 8) addr = 32'h1FFF8 + $urandom_range(0, 7);
      else addr = wild[$urandom_range(0, 3)];
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      wd   = $urandom;
      model(we, size, sgn, addr, wd, mrd, merr, mlat);
      do_access(we, size, sgn, addr, wd, rd, err, lat, ws, bs);
      checks++; if (rd !== mrd || err !== merr || lat !== mlat) begin
        errors++; $display("[TB] FAIL random[%0d] we=%b size=%0d addr=%h got rdata=%h err=%b lat=%0d want %h/%b/%0d",
                           t, we, size, addr, rd, err, lat, mrd, merr, mlat); end
      if (merr || !we) begin
        checks++; if (ws !== 1'b0) begin errors++; $display("[TB] FAIL random_we[%0d] got we=%b want 0", t, ws); end
      end
    end
    for (int i = 0; i < 65536; i++) begin
      if ((i < 16'h0048) || (i >= 16'hFFF0)) begin
        checks++; if (ram[i] !== gold[i]) begin
          errors++; $display("[TB] FAIL random_mem[%h] got=%h want=%h", 32'h10000 + i, ram[i], gold[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 8'($urandom);
      gold[i] = ram[i];
    end
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned_word();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Initiator-side load/store unit between the pipeline memory stage and the byte-addressed data memory.
- The data memory supports only word accesses and byte accesses (byte write, LBU read), with big-endian byte order: `addr+0` is the MSB.
- This block accepts full RISC-V-style loads and stores (byte, half, word; signed or unsigned). It sequences them into one or more single-cycle memory beats and returns one response per request.

Parameters:
- DATA_WIDTH, 32, data/address width.
- BYTE_WIDTH, 8, byte width.
- START_ADDRESS, 32'h10000, lowest legal data address.
- END_ADDRESS, 32'h1FFFF, highest legal data address.

Ports:
- clk_i  input  1  clock; memory writes on negedge, block state on posedge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid&&ready.
- req_we_i  input  1  1=store, 0=load.
- req_size_i  input  2  00 byte, 01 half, 10 word (11 treated as word).
- req_signed_i  input  1  sign-extend loads.
- req_addr_i  input  DATA_WIDTH  byte address.
- req_wdata_i  input  DATA_WIDTH  store data, right-aligned.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  DATA_WIDTH  load result (0 for stores and errors).
- rsp_err_o  output  1  access error, valid with rsp_valid_o.
- mem_we_o  output  1  to memory write enable.
- mem_byte_op_o  output  1  to memory byte_op.
- mem_addr_o  output  DATA_WIDTH  to memory address.
- mem_wd_o  output  DATA_WIDTH  to memory write data.
- mem_rd_i  input  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (async, immediate):
  - State IDLE; req_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - mem_we_o=0, mem_byte_op_o=0, mem_addr_o=0, mem_wd_o=0.
  - Reset mid-sequence abandons the access. Beats already written remain in memory; no response is issued.
- FSM states: IDLE, BEAT, RESP.
  - IDLE: ready=1. On accept, latch the request and check legality.
    - Legal: load beat 0 into the mem_* registers and go to BEAT.
    - Illegal: go to RESP with err=1 and no memory beat.
  - BEAT: each beat holds the mem_* registers stable for exactly one full clock, so the memory negedge write lands mid-beat. At posedge, capture the read data; then either load the next beat or go to RESP.
  - RESP: rsp_valid_o=1 for one cycle, ready=0, then IDLE. No response backpressure.
  - req_ready_o=0 in BEAT and RESP.
- Illegal access, either of:
  - any touched byte (addr .. addr+size-1) outside [START_ADDRESS, END_ADDRESS]; sum computed in DATA_WIDTH+1 bits so wrap counts as out of range;
  - word with addr[1:0]≠0.
- Beat plans (mem_we_o = req_we in all beats):
  - Word: 1 beat, byte_op=0, addr=req_addr, wd=wdata; load result = mem_rd_i.
  - Byte: 1 beat, byte_op=1, wd[31:24]=wdata[7:0], other bits 0; load byte = mem_rd_i[7:0].
  - Half: 2 byte beats, addr then addr+1.
    - Store: beat0 wd[31:24]=wdata[15:8], beat1 wd[31:24]=wdata[7:0].
    - Load: beat0 byte → result[15:8], beat1 byte → result[7:0].
- Extension: byte/half results are sign-extended if req_signed_i, otherwise zero-extended.
- Latency from accept edge to rsp_valid_o rising: byte/word 2 cycles, half 3 cycles, error 1 cycle. Next accept is possible in the cycle after RESP.
- mem_we_o is 0 in IDLE and RESP. Halfwords have no alignment requirement.

Optional Feature:
- Macro: LSU_MISALIGNED_WORD_EN.
- Defined: a misaligned in-range word is executed as 4 byte beats at addr..addr+3.
  - Store: MSB first, each byte in wd[31:24].
  - Load: result assembled MSB first.
  - Latency 5 cycles.
- Undefined: misaligned word returns rsp_err_o=1 with no memory beat.

Test Plan:
- Memory 0x10000..0x10003 = 12 34 56 78; word load 0x10000 → rsp_rdata_o=0x12345678, err=0, rsp 2 cycles after accept, mem_byte_op_o=0.
- ram[0x10003]=0x80; LB signed → 0xFFFFFF80; LBU → 0x00000080; mem_we_o never high.
- Store half 0xBEEF at 0x10002 (unaligned-to-word legal) → ram[0x10002]=0xBE, ram[0x10003]=0xEF; two beats; rsp 3 cycles after accept; a word load at 0x10000 then returns 0x1234BEEF.
- Word load 0x10001:
  - without macro → err=1, rdata=0, 1-cycle latency;
  - with LSU_MISALIGNED_WORD_EN and ram[0x10004]=0x9A → 0x3456789A.
- Out-of-range accesses → err=1 and mem_we_o stays 0 throughout:
  - word store at 0x20000;
  - half load at 0x1FFFF (second byte out of range);
  - byte at 0x0000FFFF.
- rst_ni low during beat 0 of a half store 0xBEEF at 0x10010 → mem_we_o drops immediately, no rsp_valid_o, ram[0x10011] unchanged, req_ready_o=1 after release.
